// File: rtl/stream_arb2_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared definitions for the two-source round-robin stream arbiter.
//   DEF_DATA_W : default data word width
//   DEF_CNT_W  : default saturating grant-counter width
//   word_t     : one data word at the default width
//   src_e      : source identifier used for grant, last-grant pointer and sel
// -----------------------------------------------------------------------------
package stream_arb_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_CNT_W  = 8;

  typedef logic [DEF_DATA_W-1:0] word_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_e;

endpackage : stream_arb_pkg

// File: rtl/stream_arb2_if.sv
// -----------------------------------------------------------------------------
// stream_arb2_if
// Bundles the two producer handshakes, the consumer handshake, the selector
// control line and the debug counters of stream_arb2.
//   d0/v0/r0, d1/v1/r1 : producer valid/ready channels
//   y/y_valid/y_ready  : registered consumer channel
//   sel                : select of the last accepted word (0 = d0, 1 = d1)
//   cnt0/cnt1          : saturating per-source accept counts
// Modports:
//   slave  : the arbiter side
//   master : the environment side (producers, consumer, observers)
// -----------------------------------------------------------------------------
interface stream_arb2_if
  import stream_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [DATA_W-1:0] d0;
  logic              v0;
  logic              r0;
  logic [DATA_W-1:0] d1;
  logic              v1;
  logic              r1;
  logic [DATA_W-1:0] y;
  logic              y_valid;
  logic              y_ready;
  logic              sel;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  modport slave (
    input  d0, v0, d1, v1, y_ready,
    output r0, r1, y, y_valid, sel, cnt0, cnt1
  );

  modport master (
    output d0, v0, d1, v1, y_ready,
    input  r0, r1, y, y_valid, sel, cnt0, cnt1
  );

endinterface : stream_arb2_if

// File: rtl/stream_arb2_sat_cnt.sv
// -----------------------------------------------------------------------------
// sat_cnt
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : add one on the next rising edge (ignored once saturated)
//   q     : current count
// -----------------------------------------------------------------------------
module sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule : sat_cnt

// File: rtl/stream_arb2.sv
// -----------------------------------------------------------------------------
// stream_arb2
// Two-source round-robin arbiter with a registered output stage, placed
// directly upstream of a 2:1 data selector.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream_arb2_if.slave
//           d0/v0/r0, d1/v1/r1 producer handshakes,
//           y/y_valid/y_ready registered consumer handshake,
//           sel selector control, cnt0/cnt1 saturating accept counts
// The output register loads whenever it is empty or being drained, so a word
// can leave and a new one enter on the same edge (one word per cycle).
// -----------------------------------------------------------------------------
module stream_arb2
  import stream_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_arb2_if.slave   bus
);

  // Output stage and round-robin state.
  logic [DATA_W-1:0] y_q,       y_d;
  logic              y_valid_q, y_valid_d;
  src_e              sel_q,     sel_d;
  src_e              last_q,    last_d;

  // Arbitration.
  logic ld;
  src_e grant;
  logic r0_w;
  logic r1_w;
  logic xfer0;
  logic xfer1;

  // The register can take a word when it is empty or its word leaves now.
  assign ld = ~y_valid_q | bus.y_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant = SRC0;
    if (bus.v0 && bus.v1) begin
      // Contention: the source that did not win last time goes now.
      grant = (last_q == SRC0) ? SRC1 : SRC0;
    end else if (bus.v1) begin
      grant = SRC1;
    end
  end

  // Readies depend on the valids (through grant) but never the reverse.
  assign r0_w  = ld & bus.v0 & (grant == SRC0);
  assign r1_w  = ld & bus.v1 & (grant == SRC1);
  assign xfer0 = bus.v0 & r0_w;
  assign xfer1 = bus.v1 & r1_w;

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    sel_d     = sel_q;
    last_d    = last_q;
    if (xfer0) begin
      y_d       = bus.d0;
      y_valid_d = 1'b1;
      sel_d     = SRC0;
      last_d    = SRC0;
    end else if (xfer1) begin
      y_d       = bus.d1;
      y_valid_d = 1'b1;
      sel_d     = SRC1;
      last_d    = SRC1;
    end else if (y_valid_q && bus.y_ready) begin
      // Drain with nothing to replace it: data and sel keep their values.
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sel_q     <= SRC0;
      // Pointer starts at source 1 so source 0 wins the first contest.
      last_q    <= SRC1;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
    end
  end

  sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (xfer0),
    .q     (bus.cnt0)
  );

  sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (xfer1),
    .q     (bus.cnt1)
  );

  assign bus.r0      = r0_w;
  assign bus.r1      = r1_w;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.sel     = sel_q;

endmodule : stream_arb2

// File: tb/tb_stream_arb2.sv
// -----------------------------------------------------------------------------
// tb_stream_arb2
// Directed self-checking bench for stream_arb2. Inputs change 1 time unit
// after a rising edge; outputs are sampled at that same point, well away
// from the next edge.
// -----------------------------------------------------------------------------
module tb_stream_arb2;
  import stream_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  stream_arb2_if #(.DATA_W(DEF_DATA_W), .CNT_W(DEF_CNT_W)) bus ();

  stream_arb2 #(
    .DATA_W (DEF_DATA_W),
    .CNT_W  (DEF_CNT_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.v0      = 1'b0;
    bus.v1      = 1'b0;
    bus.d0      = '0;
    bus.d1      = '0;
    bus.y_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus.y_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_y_valid got %b exp 0", bus.y_valid); end
    tests_run++; if (bus.r0 !== 1'b0) begin tests_failed++; $display("FAIL reset_r0 got %b exp 0", bus.r0); end
    tests_run++; if (bus.r1 !== 1'b0) begin tests_failed++; $display("FAIL reset_r1 got %b exp 0", bus.r1); end
    tests_run++; if (bus.sel !== 1'b0) begin tests_failed++; $display("FAIL reset_sel got %b exp 0", bus.sel); end
    tests_run++; if (bus.cnt0 !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt0 got %0d exp 0", bus.cnt0); end
    tests_run++; if (bus.cnt1 !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt1 got %0d exp 0", bus.cnt1); end
    tests_run++; if (bus.y !== 4'h0) begin tests_failed++; $display("FAIL reset_y got %h exp 0", bus.y); end
    tick();
    tests_run++; if (bus.y_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_y_valid got %b exp 0", bus.y_valid); end
  endtask

  task automatic test_single_source();
    word_t vec [3];
    vec[0] = 4'h3; vec[1] = 4'h5; vec[2] = 4'h9;
    bus.y_ready = 1'b1;
    bus.v0      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.d0 = vec[i];
      #1;
      tests_run++; if (bus.r0 !== 1'b1) begin tests_failed++; $display("FAIL single_r0[%0d] got %b exp 1", i, bus.r0); end
      tick();
      tests_run++; if (bus.y !== vec[i]) begin tests_failed++; $display("FAIL single_y[%0d] got %h exp %h", i, bus.y, vec[i]); end
      tests_run++; if (bus.sel !== 1'b0) begin tests_failed++; $display("FAIL single_sel[%0d] got %b exp 0", i, bus.sel); end
      tests_run++; if (bus.y_valid !== 1'b1) begin tests_failed++; $display("FAIL single_y_valid[%0d] got %b exp 1", i, bus.y_valid); end
    end
    bus.v0 = 1'b0;
    tests_run++; if (bus.cnt0 !== 8'd3) begin tests_failed++; $display("FAIL single_cnt0 got %0d exp 3", bus.cnt0); end
    tests_run++; if (bus.cnt1 !== 8'd0) begin tests_failed++; $display("FAIL single_cnt1 got %0d exp 0", bus.cnt1); end
    tick();
    // Drain with no new word: valid drops, data and sel hold.
    tests_run++; if (bus.y_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_y_valid got %b exp 0", bus.y_valid); end
    tests_run++; if (bus.y !== 4'h9) begin tests_failed++; $display("FAIL drain_y_hold got %h exp 9", bus.y); end
    tests_run++; if (bus.sel !== 1'b0) begin tests_failed++; $display("FAIL drain_sel_hold got %b exp 0", bus.sel); end
  endtask

  task automatic test_contention();
    word_t exp_y;
    logic  exp_sel;
    do_reset();
    bus.y_ready = 1'b1;
    bus.v0 = 1'b1; bus.d0 = 4'hA;
    bus.v1 = 1'b1; bus.d1 = 4'h5;
    for (int i = 0; i < 6; i++) begin
      exp_sel = (i % 2 == 1);
      exp_y   = exp_sel ? 4'h5 : 4'hA;
      #1;
      tests_run++; if ({bus.r1, bus.r0} !== (exp_sel ? 2'b10 : 2'b01)) begin tests_failed++; $display("FAIL contend_ready[%0d] got r1r0=%b%b exp sel %0d", i, bus.r1, bus.r0, exp_sel); end
      tick();
      tests_run++; if (bus.y !== exp_y) begin tests_failed++; $display("FAIL contend_y[%0d] got %h exp %h", i, bus.y, exp_y); end
      tests_run++; if (bus.sel !== exp_sel) begin tests_failed++; $display("FAIL contend_sel[%0d] got %b exp %b", i, bus.sel, exp_sel); end
    end
    bus.v0 = 1'b0;
    bus.v1 = 1'b0;
    tests_run++; if (bus.cnt0 !== 8'd3) begin tests_failed++; $display("FAIL contend_cnt0 got %0d exp 3", bus.cnt0); end
    tests_run++; if (bus.cnt1 !== 8'd3) begin tests_failed++; $display("FAIL contend_cnt1 got %0d exp 3", bus.cnt1); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    bus.y_ready = 1'b1;
    bus.v1 = 1'b1; bus.d1 = 4'hC;
    tick();
    bus.v1 = 1'b0;
    bus.v0 = 1'b1; bus.d0 = 4'h7;
    bus.y_ready = 1'b0;
    #1;
    tests_run++; if (bus.r0 !== 1'b0) begin tests_failed++; $display("FAIL stall_r0_init got %b exp 0", bus.r0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++; if (bus.y !== 4'hC) begin tests_failed++; $display("FAIL stall_y[%0d] got %h exp c", i, bus.y); end
      tests_run++; if (bus.y_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_y_valid[%0d] got %b exp 1", i, bus.y_valid); end
      tests_run++; if (bus.sel !== 1'b1) begin tests_failed++; $display("FAIL stall_sel[%0d] got %b exp 1", i, bus.sel); end
      tests_run++; if (bus.r0 !== 1'b0) begin tests_failed++; $display("FAIL stall_r0[%0d] got %b exp 0", i, bus.r0); end
    end
    bus.y_ready = 1'b1;
    #1;
    tests_run++; if (bus.r0 !== 1'b1) begin tests_failed++; $display("FAIL release_r0 got %b exp 1", bus.r0); end
    tick();
    bus.v0 = 1'b0;
    tests_run++; if (bus.y !== 4'h7) begin tests_failed++; $display("FAIL release_y got %h exp 7", bus.y); end
    tests_run++; if (bus.sel !== 1'b0) begin tests_failed++; $display("FAIL release_sel got %b exp 0", bus.sel); end
    tests_run++; if (bus.y_valid !== 1'b1) begin tests_failed++; $display("FAIL release_y_valid got %b exp 1", bus.y_valid); end
    tests_run++; if (bus.cnt0 !== 8'd1) begin tests_failed++; $display("FAIL release_cnt0 got %0d exp 1", bus.cnt0); end
    tests_run++; if (bus.cnt1 !== 8'd1) begin tests_failed++; $display("FAIL release_cnt1 got %0d exp 1", bus.cnt1); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.y_ready = 1'b1;
    bus.v1 = 1'b1; bus.d1 = 4'h1;
    repeat (254) tick();
    tests_run++; if (bus.cnt1 !== 8'd254) begin tests_failed++; $display("FAIL sat_cnt1_254 got %0d exp 254", bus.cnt1); end
    tick();
    tests_run++; if (bus.cnt1 !== 8'd255) begin tests_failed++; $display("FAIL sat_cnt1_255 got %0d exp 255", bus.cnt1); end
    repeat (5) tick();
    tests_run++; if (bus.cnt1 !== 8'd255) begin tests_failed++; $display("FAIL sat_cnt1_hold got %0d exp 255", bus.cnt1); end
    tests_run++; if (bus.cnt0 !== 8'd0) begin tests_failed++; $display("FAIL sat_cnt0 got %0d exp 0", bus.cnt0); end
    bus.v1 = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.y_ready = 1'b0;
    bus.v0 = 1'b1; bus.d0 = 4'h9;
    tick();
    bus.v0 = 1'b0;
    tests_run++; if ({bus.y_valid, bus.y} !== 5'h19) begin tests_failed++; $display("FAIL areset_pre got valid=%b y=%h exp valid=1 y=9", bus.y_valid, bus.y); end
    #2;
    rst_n = 1'b0;
    #1;
    // No clock edge has occurred since rst_n fell.
    tests_run++; if (bus.y_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_y_valid got %b exp 0", bus.y_valid); end
    tests_run++; if (bus.y !== 4'h0) begin tests_failed++; $display("FAIL areset_y got %h exp 0", bus.y); end
    tests_run++; if (bus.cnt0 !== 8'd0) begin tests_failed++; $display("FAIL areset_cnt0 got %0d exp 0", bus.cnt0); end
    tests_run++; if (bus.cnt1 !== 8'd0) begin tests_failed++; $display("FAIL areset_cnt1 got %0d exp 0", bus.cnt1); end
    #1;
    rst_n = 1'b1;
    bus.y_ready = 1'b1;
    bus.v0 = 1'b1; bus.d0 = 4'h2;
    bus.v1 = 1'b1; bus.d1 = 4'h6;
    #1;
    tests_run++; if ({bus.r1, bus.r0} !== 2'b01) begin tests_failed++; $display("FAIL areset_first_ready got r1r0=%b%b exp 01", bus.r1, bus.r0); end
    tick();
    tests_run++; if (bus.y !== 4'h2) begin tests_failed++; $display("FAIL areset_first_y got %h exp 2", bus.y); end
    tests_run++; if (bus.sel !== 1'b0) begin tests_failed++; $display("FAIL areset_first_sel got %b exp 0", bus.sel); end
    bus.v0 = 1'b0;
    bus.v1 = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.v0       = 1'b0;
    bus.v1       = 1'b0;
    bus.d0       = '0;
    bus.d1       = '0;
    bus.y_ready  = 1'b0;
    test_reset();
    test_single_source();
    test_contention();
    test_back_pressure();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_stream_arb2
